alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//   Execution-side consumer of the 3-bit ALU control code produced by the ALU decoder.
//   Takes one operation at a time (code + operands) over a valid/ready handshake.
//   Returns a registered result plus zero/illegal flags over a second valid/ready handshake.
//   SLL runs on an iterative 1-bit-per-cycle shifter; all other ops finish in one cycle.
//   Sits between the control decode and the writeback/branch logic in the multi-cycle datapath variant.
// PARAMETERS
//   WIDTH    32  operand/result width in bits
//   SHAMT_W  5   shift-amount width; must satisfy 2**SHAMT_W <= WIDTH
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        op request valid
//   in_ready   out  1        unit can accept a request
//   alu_ctr    in   3        000 AND, 001 OR, 010 ADD, 011 XOR, 100 SLT, 101 SLL, 110 SUB, 111 illegal
//   a          in   WIDTH    operand A (rs)
//   b          in   WIDTH    operand B (rt / immediate); SLL shifts b
//   shamt      in   SHAMT_W  shift amount, used only for SLL
//   out_valid  out  1        result valid
//   out_ready  in   1        consumer takes result
//   result     out  WIDTH    registered result
//   zero       out  1        result == 0
//   illegal    out  1        accepted alu_ctr was 111
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE, result=0, zero=0, illegal=0, out_valid=0, shift counter=0.
//   in_ready = (state==IDLE) & rst_n, so in_ready is 0 while reset is asserted.
//   FSM:
//   - IDLE: accept when in_valid & in_ready at a rising edge.
//       - Non-SLL, or SLL with shamt==0: compute, register result/flags, go to DONE.
//       - SLL with shamt!=0: load shift reg=b, counter=shamt, go to SHIFT.
//   - SHIFT: each cycle, shift reg <<= 1 (zero fill) and counter -= 1.
//       - On the edge where counter goes 1->0: register result=shift reg<<1, go to DONE.
//       - Inputs are ignored while in SHIFT.
//   - DONE: out_valid=1; result, zero and illegal are held stable.
//       - out_ready=1 at an edge -> go to IDLE, out_valid=0 next cycle.
//       - out_valid never drops without a handshake.
//   Latency (acceptance edge to first cycle with out_valid=1):
//   - 1 cycle for every op except SLL with shamt!=0.
//   - 1+shamt cycles for SLL with shamt!=0.
//   Throughput: at most one op per 2 cycles (no accept in DONE; same-cycle out_ready and in_valid
//   do not overlap).
//   Arithmetic:
//   - ADD/SUB are modulo 2**WIDTH; no overflow flag.
//   - SLT is signed compare: result = {WIDTH-1 zeros, $signed(a)<$signed(b)}.
//   - AND/OR/XOR are bitwise.
//   - SLL result = b << shamt; bits shifted past the MSB are lost.
//   Illegal code 111: result=0, zero=1, illegal=1, completes in 1 cycle like a normal op.
//   zero and illegal are registered with result in the same edge; illegal=0 for all legal ops.
//   Reset mid-SHIFT or mid-DONE: op discarded, all outputs return to reset values immediately.
//   Operands are sampled only at the acceptance edge; later input changes do not affect the op in flight.
// TESTING
//   1. ADD a=0xFFFFFFFF b=1, out_ready=1 -> out_valid 1 cycle after accept, result=0, zero=1, illegal=0.
//   2. SUB a=5 b=7 -> result=0xFFFFFFFE, zero=0.
//      SLT a=0x80000000 b=1 -> result=1.
//      SLT a=1 b=0x80000000 -> result=0.
//   3. SLL b=0x00000003 shamt=31 -> in_ready low 31 cycles, out_valid at cycle 32, result=0x80000000.
//      SLL shamt=0 b=0x1234 -> result=0x1234 after 1 cycle.
//   4. Backpressure: out_ready=0 for 5 cycles after XOR a=0xF0F0 b=0xFF00 -> result=0x0FF0 held,
//      out_valid=1 and in_ready=0 throughout; new in_valid ignored until the handshake completes.
//   5. alu_ctr=111 a=9 b=9 -> result=0, zero=1, illegal=1.
//      Next op OR a=0 b=0 -> illegal=0, zero=1.
//   6. Assert rst_n=0 during cycle 3 of an SLL shamt=10 -> out_valid=0, result=0 asynchronously.
//      After release, in_ready=1 and ADD 2+3 -> result=5.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU executing the decoder's 3-bit control code, with an iterative SLL
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         alu_ctr,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               illegal
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] sreg, res_nxt, shifted;
    logic [SHAMT_W-1:0] cnt;
    logic accept, start_shift, last_shift;
    assign in_ready    = (state == IDLE) & rst_n;
    assign out_valid   = state == DONE;
    assign accept      = in_valid & in_ready;
    assign start_shift = (alu_ctr == 3'b101) && (shamt != '0);
    assign last_shift  = (state == SHIFT) && (cnt == SHAMT_W'(1));
    assign shifted     = sreg << 1;
    always_comb begin
        res_nxt = '0;
        case (alu_ctr)
            3'b000:  res_nxt = a & b;
            3'b001:  res_nxt = a | b;
            3'b010:  res_nxt = a + b;
            3'b011:  res_nxt = a ^ b;
            3'b100:  res_nxt = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            3'b101:  res_nxt = b << shamt;
            3'b110:  res_nxt = a - b;
            default: res_nxt = '0;
        endcase
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? (start_shift ? SHIFT : DONE) : IDLE;
            SHIFT:   state_nxt = last_shift ? DONE : SHIFT;
            DONE:    state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sreg    <= '0;
            cnt     <= '0;
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            if (accept && start_shift) begin
                sreg <= b;
                cnt  <= shamt;
            end else if (state == SHIFT) begin
                sreg <= shifted;
                cnt  <= cnt - 1'b1;
            end
            if (accept && !start_shift) begin
                result  <= res_nxt;
                zero    <= res_nxt == '0;
                illegal <= alu_ctr == 3'b111;
            end else if (last_shift) begin
                result  <= shifted;
                zero    <= shifted == '0;
                illegal <= 1'b0;
            end
        end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and random ops checked against an arithmetic reference model
module tb_alu_exec_unit;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [2:0]  alu_ctr = '0;
    logic [31:0] a = '0, b = '0;
    logic [4:0]  shamt = '0;
    logic        in_ready, out_valid, zero, illegal;
    logic [31:0] result;
    int checks = 0, errors = 0;

    alu_exec_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctr(alu_ctr), .a(a), .b(b), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y,
                                          input logic [4:0] s);
        longint ux = longint'(x), uy = longint'(y), m = 64'h1_0000_0000;
        int sx = int'(x), sy = int'(y);
        case (c)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return 32'((ux + uy) % m);
            3'd3:    return x ^ y;
            3'd4:    return (sx < sy) ? 32'd1 : 32'd0;
            3'd5:    return 32'((uy * (longint'(1) << s)) % m);
            3'd6:    return 32'((ux - uy + m) % m);
            default: return 32'd0;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] c, input logic [31:0] av, input logic [31:0] bv,
                          input logic [4:0] sh, input int hold);
        logic [31:0] er;
        int lat, exp_lat;
        er = model(c, av, bv, sh);
        exp_lat = (c == 3'd5 && sh != 0) ? 1 + int'(sh) : 1;
        @(negedge clk);
        check("idle_ready", {31'd0, in_ready}, 1);
        alu_ctr = c; a = av; b = bv; shamt = sh; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        lat = 1;
        while (!out_valid && lat < 100) begin
            check("busy_ready", {31'd0, in_ready}, 0);
            in_valid = 1'($urandom); alu_ctr = 3'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("result", result, er);
        check("zero", {31'd0, zero}, {31'd0, er == 32'd0});
        check("illegal", {31'd0, illegal}, {31'd0, c == 3'd7});
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; alu_ctr = 3'($urandom); a = $urandom; b = $urandom;
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 1);
            check("hold_result", result, er);
            check("hold_ready", {31'd0, in_ready}, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drained", {31'd0, out_valid}, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, in_ready}, 0);
        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_result", result, 0);
        check("rst_flags", {30'd0, zero, illegal}, 0);
        rst_n = 1'b1;
        run_op(3'd2, 32'hFFFF_FFFF, 32'd1, 5'd0, 0);
        run_op(3'd6, 32'd5, 32'd7, 5'd0, 0);
        run_op(3'd4, 32'h8000_0000, 32'd1, 5'd0, 0);
        run_op(3'd4, 32'd1, 32'h8000_0000, 5'd0, 0);
        run_op(3'd5, 32'd0, 32'd3, 5'd31, 0);
        run_op(3'd5, 32'd0, 32'h1234, 5'd0, 0);
        run_op(3'd3, 32'hF0F0, 32'hFF00, 5'd0, 5);
        run_op(3'd7, 32'd9, 32'd9, 5'd0, 0);
        run_op(3'd1, 32'd0, 32'd0, 5'd0, 0);
        run_op(3'd3, 32'd1, 32'd2, 5'd0, 0);
        // reset in the third shift cycle must clear the earlier nonzero result at once
        @(negedge clk);
        alu_ctr = 3'd5; b = 32'd1; shamt = 5'd10; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", {31'd0, out_valid}, 0);
        check("async_result", result, 0);
        check("async_ready", {31'd0, in_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd2, 32'd2, 32'd3, 5'd0, 0);
        for (int n = 0; n < 200; n++) begin
            logic [31:0] ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            run_op(3'($urandom_range(0, 7)), ra, rb, 5'($urandom), $urandom_range(0, 2));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
